// File: rtl/digest_serializer_256b.sv
// digest_serializer_256b
// Accepts a full digest word on a valid/ready handshake and streams it out
// MSB-first as NBYTES bytes on a valid/ready byte interface. The last byte is
// tagged with out_last. Back-to-back digests chain with no idle cycle.
// The shift register is cleared whenever the block returns to IDLE.

module digest_serializer_256b #(
  parameter int NBYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dig_valid,
  output logic                  dig_ready,
  input  logic [8*NBYTES-1:0]   dig_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int DW = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            send_s;
  logic            last_s;
  logic            byte_hs_s;

  // Output decode, taken straight from the registered state.
  always_comb begin
    send_s    = (state_q == SEND);
    last_s    = send_s && (cnt_q == LAST_CNT);
    byte_hs_s = send_s && out_ready;
    out_valid = send_s;
    busy      = send_s;
    out_data  = shreg_q[DW-1 -: 8];
    out_last  = last_s;
    // Combinational out_ready -> dig_ready path lets frames chain without a bubble.
    dig_ready = !send_s || (last_s && out_ready);
  end

  // Next-state logic: load, shift on each accepted byte, clear on frame end.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dig_valid) begin
          state_d = SEND;
          shreg_d = dig_data;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (byte_hs_s) begin
          if (last_s) begin
            if (dig_valid) begin
              // Chain the next digest directly onto the finished frame.
              state_d = SEND;
              shreg_d = dig_data;
              cnt_d   = {CW{1'b0}};
            end else begin
              // Frame done: zeroize the buffer on the way back to IDLE.
              state_d = IDLE;
              shreg_d = {DW{1'b0}};
              cnt_d   = {CW{1'b0}};
            end
          end else begin
            shreg_d = {shreg_q[DW-9:0], 8'h00};
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          // Backpressure: everything holds.
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = {DW{1'b0}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers with asynchronous clear; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= {DW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_digest_serializer_256b.sv
// Self-checking bench for digest_serializer_256b. Expected bytes are pushed
// to a scoreboard queue when a digest is accepted and popped on each byte
// handshake. Inputs change at the falling edge; outputs are sampled 1 ns later.

module tb_digest_serializer_256b;

  localparam int NB = 32;
  localparam int DW = 8 * NB;

  logic          clk = 1'b0;
  logic          rst;
  logic          dig_valid;
  logic          dig_ready;
  logic [DW-1:0] dig_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;

  logic [8:0]    sb_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            ov_cnt = 0;
  int            dr_cnt = 0;
  logic          stall_r = 1'b0;
  logic [7:0]    stall_data = 8'h00;
  logic          stall_last = 1'b0;

  digest_serializer_256b #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] seq(input logic [7:0] base);
    logic [DW-1:0] r;
    for (int k = 0; k < NB; k++) r[DW-1-8*k -: 8] = base + 8'(k);
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    logic [DW-1:0] r;
    for (int k = 0; k < NB; k++) r[DW-1-8*k -: 8] = b;
    return r;
  endfunction

  // One clock cycle: observe settled outputs, score handshakes, move to next negedge.
  task automatic tick();
    logic [8:0] e;
    #1;
    if (out_valid) ov_cnt++;
    if (dig_ready) dr_cnt++;
    if (stall_r) begin
      chk("hold_data", 32'(out_data), 32'(stall_data));
      chk("hold_last", 32'(out_last), 32'(stall_last));
    end
    stall_r    = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("data", 32'(out_data), 32'(e[7:0]));
        chk("last", 32'(out_last), 32'(e[8]));
      end
    end
    if (dig_valid && dig_ready) begin
      for (int k = 0; k < NB; k++)
        sb_q.push_back({(k == NB - 1), dig_data[DW-1-8*k -: 8]});
    end
    @(negedge clk);
  endtask

  // Run until the scoreboard is empty or the cycle budget expires.
  task automatic drain(input int max_cyc, input bit bp);
    int i;
    i = 0;
    while (sb_q.size() > 0 && i < max_cyc) begin
      out_ready = bp ? ((i % 2) == 0) : 1'b1;
      tick();
      i++;
    end
    out_ready = 1'b1;
    chk("drain_done", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    dig_valid = 1'b0;
    dig_data  = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ready", 32'(dig_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single digest 0x00..0x1F at full rate.
    dig_data  = seq(8'h00);
    dig_valid = 1'b1;
    ov_cnt    = 0;
    tick();
    dig_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'h00);
    repeat (33) tick();
    chk("single_cnt",   32'(ov_cnt),     32'd32);
    chk("single_empty", 32'(sb_q.size()), 32'd0);
    chk("single_idle",  32'(out_valid),  32'd0);
    chk("single_zero",  32'(out_data),   32'h00);

    // Backpressure: out_ready low every other cycle.
    dig_data  = seq(8'h00);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    drain(100, 1'b1);
    tick();
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back: A = all 0xAA, B = all 0x55, no gap.
    dig_data  = fill(8'hAA);
    dig_valid = 1'b1;
    ov_cnt    = 0;
    dr_cnt    = 0;
    tick();
    dig_data  = fill(8'h55);
    repeat (32) tick();
    dig_valid = 1'b0;
    repeat (31) tick();
    chk("b2b_ready_pulses", 32'(dr_cnt), 32'd2);
    chk("b2b_no_gap",       32'(ov_cnt), 32'd63);
    drain(5, 1'b0);
    tick();
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Ignored dig_valid mid-frame.
    dig_data  = seq(8'h40);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    dr_cnt    = 0;
    repeat (5) tick();
    dig_data  = fill(8'hFF);
    dig_valid = 1'b1;
    repeat (10) tick();
    dig_valid = 1'b0;
    repeat (16) tick();
    chk("ign_ready_low", 32'(dr_cnt), 32'd0);
    drain(5, 1'b0);
    ov_cnt = 0;
    repeat (5) tick();
    chk("ign_no_frame", 32'(ov_cnt), 32'd0);

    // Asynchronous reset after byte 10.
    dig_data  = seq(8'h00);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    repeat (11) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_last",  32'(out_last),  32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_ready", 32'(dig_ready), 32'd1);
    sb_q.delete();
    stall_r = 1'b0;
    @(negedge clk);
    chk("arst_hold_valid", 32'(out_valid), 32'd0);
    chk("arst_hold_ready", 32'(dig_ready), 32'd1);
    rst       = 1'b0;
    dig_data  = seq(8'h20);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    chk("arst_first", 32'(out_data), 32'h20);
    drain(40, 1'b0);

    // Zeroization after a frame of 0xFF.
    dig_data  = fill(8'hFF);
    dig_valid = 1'b1;
    tick();
    dig_valid = 1'b0;
    drain(40, 1'b0);
    tick();
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_data",  32'(out_data),  32'h00);
    chk("zero_shreg", 32'(|dut.shreg_q), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/digest_serializer_256b.md
# digest_serializer_256b

Byte-stream transmitter for a 256-bit SHA-256 digest, the output-side counterpart of the 32-byte message input buffer. It accepts a full digest word on a valid/ready handshake and emits it as 32 bytes, big-endian, on a valid/ready byte stream. The final byte is flagged with `out_last`. It sits between the hash core's digest output and the byte-wide host/SPI response path.

## Interface
Parameters:
- `NBYTES`, 32: bytes per digest. Must be ≥ 2. Digest width is 8*NBYTES.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `dig_valid`  in  1  digest word available
- `dig_ready`  out  1  block can accept a digest this cycle
- `dig_data`  in  8*NBYTES  digest; bits [8*NBYTES-1 -: 8] are byte 0
- `out_valid`  out  1  `out_data` holds a valid byte
- `out_ready`  in  1  downstream accepts the byte
- `out_data`  out  8  current byte
- `out_last`  out  1  current byte is byte NBYTES-1
- `busy`  out  1  frame in progress (equals `out_valid`)

## Operation
- State machine has two states.
  - IDLE: `dig_ready`=1, `out_valid`=0.
  - SEND: `out_valid`=1.
- Internal state:
  - `shreg` (8*NBYTES bits): shift register.
  - `cnt` (ceil(log2(NBYTES)) bits): byte counter, 0..NBYTES-1, never wraps past NBYTES-1.
- Load: when `dig_valid && dig_ready`, do all of the following, then go to SEND:
  - `shreg` ← `dig_data`
  - `cnt` ← 0
- Output, driven combinationally from registers:
  - `out_data` = `shreg[8*NBYTES-1 -: 8]`
  - `out_last` = SEND && `cnt`==NBYTES-1
- Byte handshake (`out_valid && out_ready`), when not last:
  - `shreg` ← `shreg` << 8, zero-filled.
  - `cnt` ← `cnt`+1.
- Last-byte handshake (`out_last && out_ready`):
  - If `dig_valid` is high the same cycle, load the new digest, set `cnt` ← 0 and stay in SEND. This gives zero bubble between frames.
  - Otherwise, set `shreg` ← 0 and `cnt` ← 0, and go to IDLE.
- `dig_ready` = IDLE || (SEND && `out_last` && `out_ready`). This is a combinational path from `out_ready` to `dig_ready`, by design.
- `dig_valid` in SEND before the last-byte handshake is ignored. `dig_data` is not sampled.
- Zeroization: `shreg` is all-zero whenever the block is in IDLE. `out_data` therefore reads 0x00 when idle.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_last`, `cnt` and `shreg` hold.
- `out_valid` never deasserts mid-frame. Once set, it stays high until the last-byte handshake with no new load.

## Timing
- Reset (`rst`=1, takes effect immediately, independent of `clk`):
  - State = IDLE.
  - `shreg`=0, `cnt`=0.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0x00, `busy`=0, `dig_ready`=1. `dig_ready`=1 holds while `rst` is asserted.
- Reset mid-frame: the partial frame is discarded. There is no further `out_valid` until a new load.
- First cycle after `rst` deasserts: a load is accepted normally.
- Latency: load at edge N gives `out_valid`=1 with byte 0 in cycle N+1. Latency is one cycle, with no combinational path from `dig_data` to `out_data`.
- With `out_ready` held at 1:
  - Byte k appears in cycle N+1+k.
  - `out_last` is high in cycle N+NBYTES.
  - The block is in IDLE (or loading the next digest) after edge N+NBYTES.
- Throughput:
  - Back-to-back digests: NBYTES bytes per NBYTES cycles.
  - Isolated digest: NBYTES+1 cycles from load to the next possible load via IDLE.

## Test plan
- Single digest, `dig_data` = bytes 0x00,0x01,…,0x1F (MSB first), `out_ready`=1 → `out_data` 0x00..0x1F in 32 consecutive cycles starting one cycle after load. `out_last`=1 only with 0x1F. `out_valid`=0 and `out_data`=0x00 afterward.
- Backpressure: same digest, `out_ready` = 0 on every odd cycle → each byte held stable while stalled. The full sequence is still 0x00..0x1F with no drops or duplicates. `out_last` is held with 0x1F until accepted.
- Back-to-back: `dig_valid` held high with digest A = all 0xAA, then digest B = all 0x55 → 32×0xAA then 32×0x55 with no idle cycle between. `dig_ready` pulses only on the cycle of A's load and on A's last-byte handshake.
- Ignored input: assert `dig_valid` with 0xFF..FF during byte 5 of a frame, drop it before the last byte → current frame unchanged. No second frame follows, and `dig_ready` stays 0 throughout SEND.
- Async reset mid-frame: assert `rst` between clock edges after byte 10 → `out_valid`/`out_last`/`out_data` go to 0 immediately, without waiting for `clk`, and `dig_ready`=1 immediately. After release, a new digest 0x20..0x3F streams correctly from 0x20.
- Zeroization: after a frame of 0xFF bytes completes with no new load → `out_data`=0x00 and internal `shreg`=0 in IDLE.
